// File: rtl/apb_regbank_pkg.sv
// Shared types and helpers for the APB register bank slave.
// State encoding, decode-error bundle and byte-offset width helper.
package apb_regbank_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  typedef struct packed {
    logic range;
    logic align;
    logic ro;
  } err_t;

  function automatic int ofs_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb_regbank_if.sv
// APB bus bundle between interconnect master and register bank slave.
// Carries request, strobes, and the ready/error/read-data response.
interface apb_regbank_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [ADDR_W-1:0]   paddr;
  logic [DATA_W/8-1:0] pstrb;
  logic [DATA_W-1:0]   pwdata;
  logic                pready;
  logic                pslverr;
  logic [DATA_W-1:0]   prdata;

  modport master (
    output psel, penable, pwrite,
    output paddr, pstrb, pwdata,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  psel, penable, pwrite,
    input  paddr, pstrb, pwdata,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/apb_regbank_ctrl.sv
// APB transfer FSM with programmable access-phase wait states.
// pready is decoded from the state and wait counter registers only.
module apb_regbank_ctrl
  import apb_regbank_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic preset,
  input  logic psel,
  input  logic penable,
  output logic pready
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pready = (state_q == ACCESS) && (cnt_q == WS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          if (cnt_q == WS) state_d = IDLE;
          else cnt_d = cnt_q + 4'd1;
        end
      end
    endcase
  end

endmodule

// File: rtl/apb_regbank_slave.sv
// APB register bank: decode, byte-strobed storage, read mux, access pulses.
// Define APB_REGBANK_SLVERR_EN to report decode errors on pslverr.
module apb_regbank_slave
  import apb_regbank_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       preset,
  apb_regbank_if.slave               apb,
  output logic [NUM_REGS*DATA_W-1:0] reg_o,
  input  logic [NUM_REGS*DATA_W-1:0] hw_val_i,
  output logic [NUM_REGS-1:0]        wr_pulse_o,
  output logic [NUM_REGS-1:0]        rd_pulse_o
);

  localparam int OFS = ofs_w(DATA_W);
  localparam int IW  = ADDR_W - OFS;
  localparam int NB  = DATA_W / 8;
  localparam int LW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IW:0] NR = (IW+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] AMASK = ADDR_W'((1 << OFS) - 1);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [IW-1:0] idx;
  logic [LW-1:0] lidx;
  logic          rdy;
  logic          done;
  logic          good;
  err_t          err;

  apb_regbank_ctrl #(
    .WAIT_STATES(WAIT_STATES)
  ) u_ctrl (
    .clk    (clk),
    .preset (preset),
    .psel   (apb.psel),
    .penable(apb.penable),
    .pready (rdy)
  );

  assign idx  = apb.paddr[ADDR_W-1:OFS];
  assign lidx = idx[LW-1:0];

  always_comb begin
    err       = '0;
    err.range = {1'b0, idx} >= NR;
    err.align = |(apb.paddr & AMASK);
    err.ro    = apb.pwrite && !err.range && RO_MASK[lidx];
  end

  // Only a live access phase may commit; an aborted one just sees rdy.
  assign done = rdy && apb.psel && apb.penable;
  assign good = done && !(|err);

  always_ff @(posedge clk) begin
    if (preset) begin
      regs_q     <= RESET_VAL;
      wr_pulse_o <= '0;
      rd_pulse_o <= '0;
    end else begin
      wr_pulse_o <= '0;
      rd_pulse_o <= '0;
      if (good && apb.pwrite) begin
        for (int b = 0; b < NB; b++) begin
          if (apb.pstrb[b])
            regs_q[lidx][8*b +: 8] <= apb.pwdata[8*b +: 8];
        end
        wr_pulse_o[lidx] <= 1'b1;
      end
      if (good && !apb.pwrite)
        rd_pulse_o[lidx] <= 1'b1;
    end
  end

  always_comb begin
    reg_o = '0;
    for (int i = 0; i < NUM_REGS; i++)
      reg_o[i*DATA_W +: DATA_W] = RO_MASK[i] ? '0 : regs_q[i];
  end

  always_comb begin
    apb.prdata = '0;
    if (rdy && !apb.pwrite && !(|err)) begin
      if (RO_MASK[lidx])
        apb.prdata = hw_val_i[lidx*DATA_W +: DATA_W];
      else
        apb.prdata = regs_q[lidx];
    end
  end

  assign apb.pready = rdy;

`ifdef APB_REGBANK_SLVERR_EN
  assign apb.pslverr = rdy && (|err);
`else
  assign apb.pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Directed plus random bench for apb_regbank_slave against a bank model.
// Expected pslverr follows APB_REGBANK_SLVERR_EN.
module tb_apb_regbank_slave;

  localparam int WS = 2;
  localparam int NR = 16;
  localparam logic [15:0] RO = 16'h8008;

  function automatic logic [511:0] mk_rst();
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < NR; i++)
      r[i*32 +: 32] = 32'h0101_0101 * i;
    return r;
  endfunction

  localparam logic [511:0] RST = mk_rst();

  logic clk = 1'b0;
  logic preset = 1'b1;
  logic [511:0] hw_flat = '0;
  logic [511:0] reg_o;
  logic [15:0] wr_pulse_o, rd_pulse_o;

  logic [31:0] mreg [NR];
  int n_assert = 0;
  int n_fail = 0;

  apb_regbank_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  apb_regbank_slave #(
    .DATA_W(32), .ADDR_W(12), .NUM_REGS(NR),
    .WAIT_STATES(WS), .RO_MASK(RO), .RESET_VAL(RST)
  ) dut (
    .clk(clk), .preset(preset), .apb(bus),
    .reg_o(reg_o), .hw_val_i(hw_flat),
    .wr_pulse_o(wr_pulse_o), .rd_pulse_o(rd_pulse_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [511:0] obs,
                       input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mreg[i] = RST[i*32 +: 32];
  endtask

  function automatic logic [511:0] exp_regs();
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < NR; i++)
      r[i*32 +: 32] = RO[i] ? 32'h0 : mreg[i];
    return r;
  endfunction

  task automatic xfer(input logic wr, input logic [11:0] addr,
                      input logic [3:0] strb, input logic [31:0] data);
    int idx, cyc;
    logic e, isro, eslv;
    logic [31:0] erd;
    logic [15:0] ewp, erp;
    idx  = int'(addr >> 2);
    isro = (idx < NR) ? RO[idx] : 1'b0;
    e = (idx >= NR) || (addr[1:0] != 2'b00) || (wr && isro);
    erd = '0;
    if (!wr && !e) erd = isro ? hw_flat[idx*32 +: 32] : mreg[idx];
`ifdef APB_REGBANK_SLVERR_EN
    eslv = e;
`else
    eslv = 1'b0;
`endif
    ewp = (wr && !e) ? (16'h1 << idx) : 16'h0;
    erp = (!wr && !e) ? (16'h1 << idx) : 16'h0;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = addr; bus.pstrb = strb; bus.pwdata = data;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    cyc = 1;
    while (!bus.pready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("lat@%0h", addr), cyc, WS + 1);
    check($sformatf("slverr@%0h", addr), bus.pslverr, eslv);
    if (!wr) check($sformatf("prdata@%0h", addr), bus.prdata, erd);
    if (wr && !e)
      for (int b = 0; b < 4; b++)
        if (strb[b]) mreg[idx][8*b +: 8] = data[8*b +: 8];
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    check($sformatf("wrp@%0h", addr), wr_pulse_o, ewp);
    check($sformatf("rdp@%0h", addr), rd_pulse_o, erp);
    check($sformatf("regs@%0h", addr), reg_o, exp_regs());
    check($sformatf("rdyoff@%0h", addr), bus.pready, 1'b0);
  endtask

  initial begin
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pstrb = '0; bus.pwdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 preset = 1'b0;
    check("rst_pready", bus.pready, 1'b0);
    check("rst_pslverr", bus.pslverr, 1'b0);
    check("rst_prdata", bus.prdata, 32'h0);
    check("rst_wrp", wr_pulse_o, 16'h0);
    check("rst_rdp", rd_pulse_o, 16'h0);
    check("rst_regs", reg_o, exp_regs());

    xfer(1'b1, 12'h008, 4'hF, 32'hA5A5_1234);
    xfer(1'b0, 12'h008, 4'hF, 32'h0);
    check("reg2", reg_o[95:64], 32'hA5A5_1234);

    xfer(1'b1, 12'h004, 4'hF, 32'h0);
    xfer(1'b1, 12'h004, 4'b0101, 32'hFFFF_FFFF);
    check("reg1_strb", reg_o[63:32], 32'h00FF_00FF);

    hw_flat[3*32 +: 32] = 32'hDEAD_BEEF;
    xfer(1'b0, 12'h00C, 4'hF, 32'h0);
    xfer(1'b1, 12'h00C, 4'hF, 32'h1234_5678);

    xfer(1'b0, 12'h040, 4'hF, 32'h0);
    xfer(1'b1, 12'h040, 4'hF, 32'hCAFE_F00D);
    xfer(1'b1, 12'h002, 4'hF, 32'hCAFE_F00D);
    xfer(1'b0, 12'h002, 4'hF, 32'h0);
    xfer(1'b0, 12'hFFC, 4'hF, 32'h0);
    xfer(1'b1, 12'h010, 4'h0, 32'hFFFF_FFFF);

    bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b0;
    bus.paddr = 12'h000;
    repeat (3) @(posedge clk);
    #1 check("penable_idle", bus.pready, 1'b0);
    bus.psel = 1'b0; bus.penable = 1'b0;

    bus.psel = 1'b1; bus.pwrite = 1'b1; bus.paddr = 12'h014;
    bus.pstrb = 4'hF; bus.pwdata = 32'h7777_7777;
    @(posedge clk); #1;
    bus.psel = 1'b0;
    @(posedge clk); #1;
    check("abort_wrp", wr_pulse_o, 16'h0);
    check("abort_regs", reg_o, exp_regs());
    xfer(1'b1, 12'h014, 4'hF, 32'h1357_9BDF);

    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 12'h018; bus.pstrb = 4'hF; bus.pwdata = 32'h6666_6666;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(posedge clk); #1;
    preset = 1'b1;
    @(posedge clk); #1;
    preset = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
    model_reset();
    check("mid_rst_pready", bus.pready, 1'b0);
    check("mid_rst_regs", reg_o, exp_regs());
    check("mid_rst_wrp", wr_pulse_o, 16'h0);
    @(posedge clk); #1;
    check("mid_rst_idle", bus.pready, 1'b0);
    xfer(1'b1, 12'h018, 4'hF, 32'h2468_ACE0);

    for (int t = 0; t < 60; t++) begin
      logic [11:0] a;
      int k;
      hw_flat = {16{$urandom()}} ^ {$urandom(), $urandom(), 448'h0};
      k = $urandom_range(0, 9);
      if (k < 7) a = 12'($urandom_range(0, 15) * 4);
      else if (k == 7) a = 12'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else a = 12'($urandom_range(64, 4095));
      xfer(1'($urandom_range(0, 1)), a, 4'($urandom()), $urandom());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_regbank_slave.md
Name: apb_regbank_slave

Overview:
Parametrised next-generation APB slave with a configurable register bank. It implements the APB handshake with programmable wait states and per-byte strobes. It decodes errors: out-of-range address, unaligned address, and writes to read-only registers. The block sits between the APB interconnect and a peripheral core, such as the UART. It exposes the writable registers as a flattened bus, accepts hardware-owned values for read-only registers, and pulses per-register access strobes to the core.

Parameters:
DATA_W, 32, data bus width; multiple of 8, range 8..64
ADDR_W, 12, paddr width
NUM_REGS, 16, number of DATA_W-wide registers; 1..2**(ADDR_W-OFS), where OFS = clog2(DATA_W/8)
WAIT_STATES, 0, access-phase cycles with pready low before completion; 0..15
RO_MASK, {NUM_REGS{1'b0}}, bit i=1 makes register i read-only (hardware-owned)
RESET_VAL, '0, NUM_REGS*DATA_W flattened reset values for writable registers

Ports:
clk  in  1  clock, all logic on rising edge
preset  in  1  synchronous active-high reset
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  1=write, 0=read
paddr  in  ADDR_W  byte address
pstrb  in  DATA_W/8  write byte strobes
pwdata  in  DATA_W  write data
pready  out  1  transfer complete
pslverr  out  1  error response, valid only with pready
prdata  out  DATA_W  read data, valid only with pready && !pwrite
reg_o  out  NUM_REGS*DATA_W  current register contents; RO slots read 0
hw_val_i  in  NUM_REGS*DATA_W  read values for RO registers; other slots ignored
wr_pulse_o  out  NUM_REGS  1-cycle pulse after a committed write to reg i
rd_pulse_o  out  NUM_REGS  1-cycle pulse after a completed good read of reg i

Behaviour:
- Clock is clk; reset is preset, synchronous and active-high. Reset takes priority over all other events.
- Reset values: FSM=IDLE, wait_cnt=0, pready=0, pslverr=0, prdata=0, wr_pulse_o=0, rd_pulse_o=0, reg_o writable slot i = RESET_VAL slice i.
- FSM states:
  - IDLE: psel && !penable (setup phase) -> ACCESS, with wait_cnt=0.
  - ACCESS, psel=0: abort -> IDLE. No write, no pulses.
  - ACCESS, psel && penable && wait_cnt<WAIT_STATES: wait_cnt++, pready=0.
  - ACCESS, psel && penable && wait_cnt==WAIT_STATES: pready=1 for this cycle, commit on this edge, -> IDLE.
  - Back-to-back transfers: the next setup phase arrives in IDLE. There are no extra idle cycles.
- pready is a combinational decode of the state/counter registers only. With WAIT_STATES=0, pready is high in the first access cycle. Total transfer latency is 2+WAIT_STATES cycles.
- Decode:
  - idx = paddr[ADDR_W-1:OFS].
  - err_range = idx>=NUM_REGS.
  - err_align = paddr[OFS-1:0]!=0.
  - err_ro = pwrite && RO_MASK[idx].
  - err = OR of the three.
- Write commit (pready && pwrite && !err): for each lane b with pstrb[b]=1, reg[idx][8b+7:8b] <= pwdata lane b. pstrb=0 is a legal, successful no-op write, and wr_pulse still fires.
- Read: prdata = RO ? hw_val_i slice : reg slice. Driven only while pready && !pwrite && !err, otherwise 0. hw_val_i is sampled in the completion cycle.
- wr_pulse_o[idx] / rd_pulse_o[idx] are registered and high the cycle after completion, aligned with the updated reg_o. Errored transfers produce no pulse.
- pslverr = pready && err (see optional feature).
- Reset mid-transfer: the transfer is abandoned and the FSM goes to IDLE. The master must restart.
- penable high in IDLE is a protocol violation: ignored, FSM stays IDLE.

Optional Feature:
Macro APB_REGBANK_SLVERR_EN.
- Defined: pslverr behaves as above.
- Undefined: pslverr is tied 0. Errored writes are still silently dropped (no reg change, no pulse), and errored reads return 0.

Decomposition:
- Package apb_regbank_pkg holds:
  - state_t enum {IDLE, ACCESS}
  - the clog2-based OFS helper function
  - err_t struct {range, align, ro}
- Sub-module apb_regbank_ctrl holds the FSM, wait counter and pready generation. The top holds decode, register storage, read mux and pulses.

Test Plan:
- Default params, write 0xA5A5_1234 to 0x008 with pstrb=4'hF, then read 0x008 -> pready on 2nd cycle of each transfer, prdata=0xA5A5_1234, wr_pulse_o[2] high 1 cycle, pslverr=0.
- Write 0xFFFF_FFFF to 0x004 with pstrb=4'b0101 over reg=0 -> reg_o slice 1 = 0x00FF_00FF.
- WAIT_STATES=3, read 0x000 -> pready low for 3 access cycles, high on the 4th; total 5 cycles.
- RO_MASK[3]=1 with hw_val_i slice 3 = 0xDEAD_BEEF: read 0x00C -> 0xDEAD_BEEF, rd_pulse_o[3]; write 0x00C -> pslverr=1, value unchanged, no wr_pulse.
- Access 0x040 (NUM_REGS=16) and 0x002 -> pslverr=1, prdata=0, no state change. With the macro undefined -> pslverr=0, same lack of state change.
- Assert preset during the access phase of a write with WAIT_STATES=2 -> register stays at RESET_VAL, pready=0, FSM=IDLE next cycle; a following transfer completes normally.
